frame_config_writer: RTL and testbench

- Drives the configuration side of the tile frame interface: produces FrameData words and one-hot FrameStrobe pulses for one fabric column.
- A tile in that column latches a frame when its FrameStrobe bit pulses; the column is NumberOfRows tiles high.
- Consumes a 32-bit word stream with a valid/ready handshake from the bitstream source (UART/SPI loader), so it sits between the loader and the column's FrameData/FrameStrobe inputs.

---
 rtl/frame_config_writer_pkg.sv | 23 ++
 rtl/frame_strobe_decoder.sv | 25 ++
 rtl/frame_config_writer.sv | 153 +++++++++++++++
 tb/tb_frame_config_writer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_config_writer_pkg.sv
// Shared definitions for the frame configuration writer.
// Holds the stream control words, the header field layout and the
// controller state encoding used by frame_config_writer.
package frame_cfg_pkg;

  localparam logic [31:0] SYNC    = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC  = 32'hFAB0_FAB0;
  localparam logic [15:0] HDR_TAG = 16'hF0A0;

  // Header layout: tag in [31:16], frame index in [7:0], [15:8] ignored.
  localparam int HDR_TAG_LSB = 16;
  localparam int HDR_TAG_W   = 16;
  localparam int HDR_IDX_LSB = 0;
  localparam int HDR_IDX_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Binary frame index to one-hot FrameStrobe vector.
// Purely combinational; the parent registers the result.
// Ports:
//   idx_i    - frame index
//   en_i     - when low the output is all zeros
//   strobe_o - one-hot vector, bit idx_i set when enabled
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int IdxW            = 8
) (
  input  logic [IdxW-1:0]            idx_i,
  input  logic                       en_i,
  output logic [MaxFramesPerCol-1:0] strobe_o
);

  always_comb begin
    strobe_o = '0;
    if (en_i) begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        if (idx_i == IdxW'(i)) strobe_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Configuration-side frame writer for one fabric column.
// Accepts a 32-bit word stream (SYNC, then header/data frames, then
// DESYNC), assembles NumberOfRows data words into FrameData and pulses
// the one-hot FrameStrobe bit selected by the header index.
// Ports:
//   UserCLK, resetn   - clock, asynchronous active-low reset
//   s_data/s_valid/s_ready - input word stream handshake
//   FrameData         - row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe       - single-cycle one-hot frame latch pulse
//   busy              - controller not in IDLE
//   cfg_done          - one-cycle pulse after an accepted DESYNC
//   cfg_error         - sticky bad-header flag, cleared by SYNC
//   frames_written    - saturating strobe count since last SYNC
module frame_config_writer
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 2
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  input  logic [FrameBitsPerRow-1:0]              s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    busy,
  output logic                                    cfg_done,
  output logic                                    cfg_error,
  output logic [15:0]                             frames_written
);

  localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [HDR_IDX_W:0] MaxIdx = (HDR_IDX_W+1)'(MaxFramesPerCol);

  state_e                              state_q, state_d;
  logic [RowW-1:0]                     row_q, row_d;
  logic [HDR_IDX_W-1:0]                idx_q, idx_d;
  logic                                err_q, err_d;
  logic [15:0]                         cnt_q, cnt_d;
  logic                                done_d;
  logic                                wr_row;
  logic                                rdy_q;
  logic                                done_q;
  logic [MaxFramesPerCol-1:0]          strobe_q, strobe_d;
  logic [NumberOfRows*FrameBitsPerRow-1:0] fdata_q;

  logic                 accept;
  logic [HDR_IDX_W-1:0] hdr_idx;
  logic [HDR_TAG_W-1:0] hdr_tag;

  assign accept  = s_valid & rdy_q;
  assign hdr_idx = s_data[HDR_IDX_LSB +: HDR_IDX_W];
  assign hdr_tag = s_data[HDR_TAG_LSB +: HDR_TAG_W];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_row  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && s_data == SYNC) begin
          state_d = HEADER;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      HEADER: begin
        if (accept) begin
          if (s_data == DESYNC) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (hdr_tag == HDR_TAG && {1'b0, hdr_idx} < MaxIdx) begin
            idx_d   = hdr_idx;
            row_d   = '0;
            state_d = DATA;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wr_row = 1'b1;
          if (row_q == RowW'(NumberOfRows-1)) begin
            state_d = STROBE;
            row_d   = '0;
            // Count on the edge entering STROBE so the total is visible
            // together with the pulse.
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      STROBE: state_d = HEADER;
      default: state_d = IDLE;
    endcase
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .IdxW           (HDR_IDX_W)
  ) u_dec (
    .idx_i   (idx_d),
    .en_i    (state_d == STROBE),
    .strobe_o(strobe_d)
  );

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      row_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= '0;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      // Ready is registered so it is low while reset is held and drops
      // exactly for the strobe cycle.
      rdy_q    <= (state_d != STROBE);
      done_q   <= done_d;
      strobe_q <= strobe_d;
      for (int r = 0; r < NumberOfRows; r++) begin
        if (wr_row && row_q == RowW'(r))
          fdata_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
      end
    end
  end

  assign s_ready        = rdy_q;
  assign FrameData      = fdata_q;
  assign FrameStrobe    = strobe_q;
  assign busy           = (state_q != IDLE);
  assign cfg_done       = done_q;
  assign cfg_error      = err_q;
  assign frames_written = cnt_q;

endmodule

// File: tb/tb_frame_config_writer.sv
module tb_frame_config_writer;

  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic        UserCLK = 1'b0;
  logic        resetn;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [15:0] frames_written;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int          cyc = 0;
  int          done_cnt = 0;
  int          rdy_viol = 0;
  bit          mon_rdy_en = 0;
  logic [19:0] sq[$];
  logic [63:0] fq[$];
  int          cq[$];

  frame_config_writer dut (
    .UserCLK       (UserCLK),
    .resetn        (resetn),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .busy          (busy),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error),
    .frames_written(frames_written)
  );

  always #5 UserCLK = ~UserCLK;

  always @(negedge UserCLK) begin
    cyc++;
    if (FrameStrobe != 20'h0) begin
      sq.push_back(FrameStrobe);
      fq.push_back(FrameData);
      cq.push_back(cyc);
    end
    if (cfg_done) done_cnt++;
    if (mon_rdy_en && ((FrameStrobe != 20'h0) == s_ready)) rdy_viol++;
  end

  task automatic send(input logic [31:0] w, input int gap);
    bit ok;
    logic r;
    ok = 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(negedge UserCLK);
    end
    s_valid = 1'b1;
    s_data  = w;
    for (int k = 0; k < 20 && !ok; k++) begin
      r = s_ready;
      @(negedge UserCLK);
      if (r) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h not accepted within 20 cycles", w);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge UserCLK);
  endtask

  task automatic test_reset;
    resetn = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge UserCLK);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++; if (FrameData !== 64'h0) begin errors++; $display("FAIL reset_framedata: got %h want 0", FrameData); end
    checks++; if (FrameStrobe !== 20'h0) begin errors++; $display("FAIL reset_strobe: got %h want 0", FrameStrobe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", cfg_error); end
    checks++; if (frames_written !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", frames_written); end
    resetn = 1'b1;
    @(negedge UserCLK);
  endtask

  task automatic test_basic_frame;
    int nb;
    nb = sq.size();
    send(SYNC, 0);
    send(32'hF0A0_0005, 0);
    send(32'h1111_1111, 0);
    send(32'h2222_2222, 0);
    idle(3);
    checks++; if (sq.size() != nb + 1) begin errors++; $display("FAIL basic_strobe_count: got %0d want 1", sq.size() - nb); end
    if (sq.size() > nb) begin
      checks++; if (sq[nb] !== 20'h00020) begin errors++; $display("FAIL basic_strobe: got %h want 00020", sq[nb]); end
      checks++; if (fq[nb] !== 64'h2222_2222_1111_1111) begin errors++; $display("FAIL basic_framedata: got %h want 2222222211111111", fq[nb]); end
    end
    checks++; if (frames_written !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", frames_written); end
    checks++; if (FrameData !== 64'h2222_2222_1111_1111) begin errors++; $display("FAIL basic_hold: got %h want 2222222211111111", FrameData); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_header: got %b want 1", busy); end
  endtask

  task automatic test_bad_index;
    int nb;
    nb = sq.size();
    send(32'hF0A0_0014, 0);
    idle(2);
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL badidx_error: got %b want 1", cfg_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badidx_idle: busy got %b want 0", busy); end
    checks++; if (sq.size() != nb) begin errors++; $display("FAIL badidx_nostrobe: got %0d strobes want 0", sq.size() - nb); end
    send(SYNC, 0);
    idle(1);
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL sync_clears_error: got %b want 0", cfg_error); end
    checks++; if (frames_written !== 16'd0) begin errors++; $display("FAIL sync_clears_count: got %0d want 0", frames_written); end
  endtask

  task automatic test_back_to_back;
    int nb;
    nb = sq.size();
    mon_rdy_en = 1;
    send(32'hF0A0_0000, 0);
    send(32'hA0A0_0001, 0);
    send(32'hA0A0_0002, 0);
    send(32'hF0A0_0013, 0);
    send(32'hB0B0_0001, 0);
    send(32'hB0B0_0002, 0);
    idle(3);
    mon_rdy_en = 0;
    checks++; if (sq.size() != nb + 2) begin errors++; $display("FAIL b2b_strobe_count: got %0d want 2", sq.size() - nb); end
    if (sq.size() >= nb + 2) begin
      checks++; if (sq[nb] !== 20'h00001) begin errors++; $display("FAIL b2b_strobe0: got %h want 00001", sq[nb]); end
      checks++; if (sq[nb+1] !== 20'h80000) begin errors++; $display("FAIL b2b_strobe19: got %h want 80000", sq[nb+1]); end
      checks++; if (cq[nb+1] - cq[nb] != 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", cq[nb+1] - cq[nb]); end
      checks++; if (fq[nb+1] !== 64'hB0B0_0002_B0B0_0001) begin errors++; $display("FAIL b2b_framedata: got %h want B0B00002B0B00001", fq[nb+1]); end
    end
    checks++; if (rdy_viol != 0) begin errors++; $display("FAIL b2b_ready: %0d cycles with s_ready not the inverse of strobe, want 0", rdy_viol); end
    checks++; if (frames_written !== 16'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", frames_written); end
  endtask

  task automatic test_desync;
    int nb, db;
    nb = sq.size();
    db = done_cnt;
    send(32'hF0A0_0003, 0);
    send(DESYNC, 0);
    send(32'h1234_5678, 0);
    idle(3);
    checks++; if (sq.size() != nb + 1) begin errors++; $display("FAIL desyncdata_strobe_count: got %0d want 1", sq.size() - nb); end
    if (sq.size() > nb) begin
      checks++; if (sq[nb] !== 20'h00008) begin errors++; $display("FAIL desyncdata_strobe: got %h want 00008", sq[nb]); end
      checks++; if (fq[nb] !== 64'h1234_5678_FAB0_FAB0) begin errors++; $display("FAIL desyncdata_framedata: got %h want 12345678FAB0FAB0", fq[nb]); end
    end
    checks++; if (done_cnt != db) begin errors++; $display("FAIL desyncdata_nodone: got %0d pulses want 0", done_cnt - db); end
    send(DESYNC, 0);
    idle(3);
    checks++; if (done_cnt != db + 1) begin errors++; $display("FAIL desync_done_pulse: got %0d cycles want 1", done_cnt - db); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL desync_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    int nb, db;
    send(SYNC, 0);
    send(32'hF0A0_0007, 0);
    send(32'hAAAA_AAAA, 0);
    s_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks++; if (FrameData !== 64'h0) begin errors++; $display("FAIL midreset_framedata: got %h want 0", FrameData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b want 0", s_ready); end
    checks++; if (frames_written !== 16'h0) begin errors++; $display("FAIL midreset_count: got %h want 0", frames_written); end
    @(negedge UserCLK);
    resetn = 1'b1;
    nb = sq.size();
    db = done_cnt;
    send(32'hBBBB_BBBB, 0);
    send(DESYNC, 0);
    idle(4);
    checks++; if (sq.size() != nb) begin errors++; $display("FAIL midreset_nostrobe: got %0d strobes want 0", sq.size() - nb); end
    checks++; if (done_cnt != db) begin errors++; $display("FAIL midreset_nodone: got %0d pulses want 0", done_cnt - db); end
    checks++; if (FrameData !== 64'h0) begin errors++; $display("FAIL midreset_idle_data: got %h want 0", FrameData); end
  endtask

  task automatic test_gaps;
    int nb;
    nb = sq.size();
    send(SYNC, $urandom_range(0, 3));
    send(32'hF0A0_0005, $urandom_range(0, 3));
    send(32'h1111_1111, $urandom_range(0, 3));
    send(32'h2222_2222, $urandom_range(0, 3));
    idle(3);
    checks++; if (sq.size() != nb + 1) begin errors++; $display("FAIL gaps_strobe_count: got %0d want 1", sq.size() - nb); end
    if (sq.size() > nb) begin
      checks++; if (sq[nb] !== 20'h00020) begin errors++; $display("FAIL gaps_strobe: got %h want 00020", sq[nb]); end
      checks++; if (fq[nb] !== 64'h2222_2222_1111_1111) begin errors++; $display("FAIL gaps_framedata: got %h want 2222222211111111", fq[nb]); end
    end
    checks++; if (frames_written !== 16'd1) begin errors++; $display("FAIL gaps_count: got %0d want 1", frames_written); end
    send(DESYNC, 1);
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gaps_end_busy: got %b want 0", busy); end
  endtask

  initial begin
    @(negedge UserCLK);
    test_reset;
    test_basic_frame;
    test_bad_index;
    test_back_to_back;
    test_desync;
    test_reset_mid_frame;
    test_gaps;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
